// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: direct-mapped buffer in front of a req/ack instruction memory.
// Define PREFETCH_EN to enable the next-line prefetch (PF state) after each demand fill.
module inst_fetch_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BUF_ENTRIES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [ADDR_W-1:0] rom_addr_i,
    output logic [DATA_W-1:0] rom_data_o,
    output logic              stall_req_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int IDX_W = $clog2(BUF_ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
`ifdef PREFETCH_EN
    localparam logic [1:0] S_PF   = 2'd2;
`endif

    logic [1:0]             state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [BUF_ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q  [BUF_ENTRIES];
    logic [DATA_W-1:0]      data_q [BUF_ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             hit;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             busy;
    logic             ack;
    logic             discard;
    logic             fill_en;
    logic             unused_addr;

    assign rd_idx      = rom_addr_i[IDX_W+1:2];
    assign rd_tag      = rom_addr_i[ADDR_W-1:IDX_W+2];
    assign hit         = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign fill_idx    = addr_q[IDX_W+1:2];
    assign fill_tag    = addr_q[ADDR_W-1:IDX_W+2];
    assign busy        = (state_q != S_IDLE);
    assign ack         = busy && mem_ack_i;
    assign discard     = flush_i || flush_pend_q;
    assign fill_en     = ack && !discard;
    assign unused_addr = ^rom_addr_i[1:0];

    // Outputs are forced quiet while reset is held, independent of buffer state.
    assign stall_req_o = rst && rom_ce_i && (!hit || state_q == S_REQ);
    assign rom_data_o  = (rst && rom_ce_i && hit && state_q != S_REQ)
                       ? data_q[rd_idx] : '0;
    assign mem_req_o   = busy;
    assign mem_addr_o  = addr_q;

`ifdef PREFETCH_EN
    logic              pf_pend_q, pf_pend_d;
    logic [ADDR_W-1:0] pf_addr;
    logic [IDX_W-1:0]  pf_idx;
    logic [TAG_W-1:0]  pf_tag;
    logic              pf_hit;

    assign pf_addr = addr_q + ADDR_W'(4);
    assign pf_idx  = pf_addr[IDX_W+1:2];
    assign pf_tag  = pf_addr[ADDR_W-1:IDX_W+2];
    assign pf_hit  = valid_q[pf_idx] && (tag_q[pf_idx] == pf_tag);
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        flush_pend_d = flush_pend_q;
`ifdef PREFETCH_EN
        pf_pend_d    = pf_pend_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (rom_ce_i && !hit) begin
                    state_d = S_REQ;
                    addr_d  = {rom_addr_i[ADDR_W-1:2], 2'b00};
`ifdef PREFETCH_EN
                    pf_pend_d = 1'b0;
                end else if (pf_pend_q) begin
                    pf_pend_d = 1'b0;
                    if (!flush_i && !pf_hit) begin
                        state_d = S_PF;
                        addr_d  = pf_addr;
                    end
`endif
                end
            end
            S_REQ: begin
                if (mem_ack_i) begin
                    state_d      = S_IDLE;
                    flush_pend_d = 1'b0;
`ifdef PREFETCH_EN
                    // Wrap of A+4 to zero suppresses the prefetch.
                    pf_pend_d    = !discard && (pf_addr != '0);
`endif
                end else if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
            end
`ifdef PREFETCH_EN
            S_PF: begin
                if (mem_ack_i) begin
                    state_d      = S_IDLE;
                    flush_pend_d = 1'b0;
                end else if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        if (flush_i)
            valid_d = '0;
        else if (fill_en)
            valid_d[fill_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
        end
    end

`ifdef PREFETCH_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pf_pend_q <= 1'b0;
        else
            pf_pend_q <= pf_pend_d;
    end
`endif

    // Tag/data storage needs no reset: valid_q gates every read.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed self-checking bench for inst_fetch_bridge.
// Prefetch-specific expectations follow PREFETCH_EN.
module tb_inst_fetch_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [31:0] addr = '0;
    logic        flush = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;
    logic [31:0] data_o;
    logic        stall;
    logic        req;
    logic [31:0] maddr;

    int checks = 0;
    int errors = 0;
    int reqs = 0;
    logic req_prev = 1'b0;

    inst_fetch_bridge #(
        .ADDR_W(32), .DATA_W(32), .BUF_ENTRIES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .rom_ce_i(ce), .rom_addr_i(addr),
        .rom_data_o(data_o), .stall_req_o(stall),
        .flush_i(flush),
        .mem_req_o(req), .mem_addr_o(maddr),
        .mem_ack_i(ack), .mem_rdata_i(rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (req && !req_prev) reqs <= reqs + 1;
        req_prev <= req;
    end

    task automatic mem_serve(input logic [31:0] ea, input logic [31:0] d, input int lat);
        int n = 0;
        while (!req && n < 20) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (req !== 1'b1) begin
            errors++;
            $display("FAIL serve_timeout addr=%h req=%b required=1", ea, req);
            return;
        end
        checks++;
        if (maddr !== ea) begin
            errors++;
            $display("FAIL serve_addr got=%h required=%h", maddr, ea);
        end
        for (int i = 1; i < lat; i++) begin
            @(negedge clk); #1;
            checks++;
            if (req !== 1'b1 || maddr !== ea) begin
                errors++;
                $display("FAIL serve_hold req=%b addr=%h required req=1 addr=%h", req, maddr, ea);
            end
        end
        @(negedge clk);
        ack = 1'b1; rdata = d;
        @(negedge clk);
        ack = 1'b0; rdata = '0;
        #1;
    endtask

    task automatic pf_drain();
`ifdef PREFETCH_EN
        for (int i = 0; i < 3 && !req; i++) begin
            @(negedge clk); #1;
        end
        if (req) begin
            @(negedge clk);
            ack = 1'b1; rdata = 32'hAAAA_0000 | maddr;
            @(negedge clk);
            ack = 1'b0; rdata = '0;
            #1;
        end
`endif
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        ce = 1'b1; addr = 32'h40;
        #1;
        checks++;
        if (data_o !== 32'h0) begin
            errors++; $display("FAIL rst_data got=%h required=0", data_o);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL rst_stall got=%b required=0", stall);
        end
        checks++;
        if (req !== 1'b0) begin
            errors++; $display("FAIL rst_req got=%b required=0", req);
        end
        checks++;
        if (maddr !== 32'h0) begin
            errors++; $display("FAIL rst_maddr got=%h required=0", maddr);
        end
        @(negedge clk);
        ce = 1'b0; rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (stall !== 1'b0 || data_o !== 32'h0 || req !== 1'b0) begin
                errors++;
                $display("FAIL idle cyc=%0d stall=%b data=%h req=%b required 0", i, stall, data_o, req);
            end
        end
    endtask

    task automatic test_cold_miss();
        int r0;
        @(negedge clk);
        ce = 1'b1; addr = 32'h0;
        #1;
        r0 = reqs;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL cold_stall got=%b required=1", stall);
        end
        mem_serve(32'h0, 32'h3401_1100, 3);
        checks++;
        if (data_o !== 32'h3401_1100 || stall !== 1'b0) begin
            errors++;
            $display("FAIL cold_data got=%h stall=%b required=34011100 stall=0", data_o, stall);
        end
        checks++;
        if (reqs - r0 != 1) begin
            errors++; $display("FAIL cold_reqs got=%0d required=1", reqs - r0);
        end
        pf_drain();
    endtask

    task automatic test_hit_stream();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ack = (i == 4);
            rdata = 32'hDEAD_BEEF;
            #1;
            checks++;
            if (stall !== 1'b0 || data_o !== 32'h3401_1100 || req !== 1'b0) begin
                errors++;
                $display("FAIL hit cyc=%0d stall=%b data=%h req=%b required 0/34011100/0", i, stall, data_o, req);
            end
        end
        ack = 1'b0; rdata = '0;
    endtask

    task automatic test_conflict();
        @(negedge clk);
        addr = 32'h10;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL conf_miss10 stall=%b required=1", stall);
        end
        mem_serve(32'h10, 32'h1111_0010, 2);
        checks++;
        if (data_o !== 32'h1111_0010) begin
            errors++; $display("FAIL conf_data10 got=%h required=11110010", data_o);
        end
        pf_drain();
        @(negedge clk);
        addr = 32'h0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL conf_miss00 stall=%b required=1", stall);
        end
        mem_serve(32'h0, 32'h0000_0A0A, 1);
        checks++;
        if (data_o !== 32'h0000_0A0A) begin
            errors++; $display("FAIL conf_data00 got=%h required=00000a0a", data_o);
        end
        pf_drain();
    endtask

    task automatic test_flush_mid_req();
        int n = 0;
        @(negedge clk);
        addr = 32'h20;
        #1;
        while (!req && n < 5) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (req !== 1'b1) begin
            errors++; $display("FAIL flush_req_timeout req=%b required=1", req);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; ack = 1'b1; rdata = 32'h5555_5555;
        @(negedge clk);
        ack = 1'b0; rdata = '0;
        #1;
        checks++;
        if (stall !== 1'b1 || req !== 1'b0) begin
            errors++;
            $display("FAIL flush_after_ack stall=%b req=%b required 1/0", stall, req);
        end
        @(negedge clk); #1;
        checks++;
        if (req !== 1'b1 || maddr !== 32'h20) begin
            errors++;
            $display("FAIL flush_reissue req=%b addr=%h required 1/00000020", req, maddr);
        end
        mem_serve(32'h20, 32'h2020_2020, 1);
        checks++;
        if (data_o !== 32'h2020_2020 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_fill got=%h stall=%b required=20202020 stall=0", data_o, stall);
        end
        pf_drain();
    endtask

    task automatic test_prefetch();
        @(negedge clk);
        addr = 32'h100;
        #1;
        mem_serve(32'h100, 32'h0100_0100, 1);
        checks++;
        if (data_o !== 32'h0100_0100) begin
            errors++; $display("FAIL pf_demand got=%h required=01000100", data_o);
        end
        @(negedge clk);
        ce = 1'b0;
`ifdef PREFETCH_EN
        for (int i = 0; i < 5 && !req; i++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (req !== 1'b1 || maddr !== 32'h104) begin
            errors++;
            $display("FAIL pf_issue req=%b addr=%h required 1/00000104", req, maddr);
        end
        @(negedge clk);
        ack = 1'b1; rdata = 32'h0104_0104;
        @(negedge clk);
        ack = 1'b0; rdata = '0;
        ce = 1'b1; addr = 32'h104;
        #1;
        checks++;
        if (stall !== 1'b0 || data_o !== 32'h0104_0104) begin
            errors++;
            $display("FAIL pf_hit stall=%b data=%h required 0/01040104", stall, data_o);
        end
`else
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (req !== 1'b0) begin
                errors++; $display("FAIL nopf_req cyc=%0d req=%b required=0", i, req);
            end
        end
        @(negedge clk);
        ce = 1'b1; addr = 32'h104;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL nopf_miss104 stall=%b required=1", stall);
        end
        mem_serve(32'h104, 32'h0104_0104, 1);
        checks++;
        if (data_o !== 32'h0104_0104) begin
            errors++; $display("FAIL nopf_data got=%h required=01040104", data_o);
        end
`endif
    endtask

    task automatic test_reset_mid_req();
        int n = 0;
        @(negedge clk);
        addr = 32'h200;
        #1;
        while (!req && n < 5) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (req !== 1'b1) begin
            errors++; $display("FAIL rmid_req_timeout req=%b required=1", req);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (req !== 1'b0 || stall !== 1'b0 || data_o !== 32'h0 || maddr !== 32'h0) begin
            errors++;
            $display("FAIL rmid_drop req=%b stall=%b data=%h addr=%h required all 0", req, stall, data_o, maddr);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1 || req !== 1'b0) begin
            errors++;
            $display("FAIL rmid_remiss stall=%b req=%b required 1/0", stall, req);
        end
        mem_serve(32'h200, 32'h0200_0200, 2);
        checks++;
        if (data_o !== 32'h0200_0200 || stall !== 1'b0) begin
            errors++;
            $display("FAIL rmid_fill got=%h stall=%b required=02000200 stall=0", data_o, stall);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_stream();
        test_conflict();
        test_flush_mid_req();
        test_prefetch();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
